// File: rtl/cmd_pkg.sv
// Shared definitions for the host command channel: word layout, HALT opcode, FSM states.
package cmd_pkg;

    localparam int unsigned CMD_W  = 64;
    localparam int unsigned OPC_HI = 63;
    localparam int unsigned OPC_LO = 56;
    localparam int unsigned OPC_W  = OPC_HI - OPC_LO + 1;

    localparam logic [OPC_W-1:0] OPC_HALT = 8'hFF;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_WAIT = 2'd1,
        ST_DONE      = 2'd2
    } state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [CMD_W-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with flush and occupancy count; no bypass from push to head.
module cmd_fifo
    import cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = CMD_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     head_c,
    output logic             empty_c,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    // Full comes from the registered count, so a same-cycle pop never admits a push.
    always_comb begin
        do_push  = push & ~full_q & ~flush;
        do_pop   = pop & (count_q != '0) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign empty_c = (count_q == '0);
    assign full    = full_q;
    assign count   = count_q;

endmodule

// File: rtl/cmd_streamer.sv
// Host-side command transmitter: FIFO-buffered words presented to the core with
// valid/ready, halting after an OPC_HALT word, with issue counting and stall timeout.
module cmd_streamer
    import cmd_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1,
    localparam int unsigned STL_W = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_push,
    input  logic [CMD_W-1:0] host_data,
    output logic             host_full,
    output logic [LVL_W-1:0] host_level,
    input  logic             flush,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd_data,
    input  logic             cmd_ready,
    input  logic             core_halted,
    output logic             done,
    output logic             stall_timeout,
    output logic [31:0]      issued_count
);

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [CMD_W-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic [STL_W-1:0] stall_q, stall_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      issued_q, issued_d;

    logic             xfer_c, halt_xfer_c, stalled_c, pop_c;
    logic [CMD_W-1:0] fifo_head_c;
    logic             fifo_empty_c;

    cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (host_push),
        .din     (host_data),
        .pop     (pop_c),
        .flush   (flush),
        .head_c  (fifo_head_c),
        .empty_c (fifo_empty_c),
        .full    (host_full),
        .count   (host_level)
    );

    assign xfer_c      = valid_q & cmd_ready;
    assign halt_xfer_c = xfer_c & (opcode_of(data_q) == OPC_HALT);
    assign stalled_c   = valid_q & ~cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:       if (halt_xfer_c) state_d = ST_HALT_WAIT;
            ST_HALT_WAIT: if (core_halted) state_d = ST_DONE;
            ST_DONE:      state_d = ST_DONE;
            default:      state_d = ST_RUN;
        endcase
    end

    // Output register refill, counters and sticky flags; refill stops on the HALT transfer.
    always_comb begin
        pop_c     = 1'b0;
        valid_d   = valid_q;
        data_d    = data_q;
        issued_d  = issued_q;
        stall_d   = '0;
        timeout_d = timeout_q;
        if (xfer_c) begin
            valid_d  = 1'b0;
            issued_d = issued_q + 32'd1;
        end
        if ((state_q == ST_RUN) && !halt_xfer_c && (!valid_q || xfer_c)
            && !fifo_empty_c && !flush) begin
            pop_c   = 1'b1;
            valid_d = 1'b1;
            data_d  = fifo_head_c;
        end
        if (stalled_c) begin
            stall_d = (stall_q == STL_W'(TIMEOUT)) ? stall_q : stall_q + STL_W'(1);
            if (stall_q == STL_W'(TIMEOUT - 1)) timeout_d = 1'b1;
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
            issued_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            done_q    <= done_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
            issued_q  <= issued_d;
        end
    end

    assign cmd_valid     = valid_q;
    assign cmd_data      = data_q;
    assign done          = done_q;
    assign stall_timeout = timeout_q;
    assign issued_count  = issued_q;

endmodule
